// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one single-port synchronous RAM between instruction fetch and load/store
// Optional MEM_ARB_PERF_EN adds per-port wait-cycle counters (perf_if_wait, perf_d_wait).
module mem_arbiter #(
   parameter int AW         = 8,
   parameter int DW         = 32,
   parameter int MEM_LAT    = 1,
   parameter int STARVE_MAX = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic          if_gnt,
   output logic          if_rvalid,
   output logic [DW-1:0] if_rdata,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic          d_gnt,
   output logic          d_rvalid,
   output logic [DW-1:0] d_rdata,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
`ifdef MEM_ARB_PERF_EN
   ,
   output logic [31:0]   perf_if_wait,
   output logic [31:0]   perf_d_wait
`endif
);

   localparam int CW = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);
   localparam int LW = 3;
   localparam logic [CW-1:0] STARVE_CMP = CW'(STARVE_MAX);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

   state_t          state_q, state_d;
   logic            owner_q, owner_d;
   logic            we_q, we_d;
   logic [LW-1:0]   lat_q, lat_d;
   logic [CW-1:0]   starve_q, starve_d;
   logic            if_gnt_q, if_gnt_d, d_gnt_q, d_gnt_d;
   logic            if_rvalid_q, if_rvalid_d, d_rvalid_q, d_rvalid_d;
   logic [DW-1:0]   if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
   logic            mem_en_q, mem_en_d, mem_we_q, mem_we_d;
   logic [AW-1:0]   mem_addr_q, mem_addr_d;
   logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
   logic            d_wins;

   // Data port wins unless fetch has been passed over STARVE_MAX times in a row.
   assign d_wins = d_req && !(if_req && (starve_q == STARVE_CMP));

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      we_d        = we_q;
      lat_d       = lat_q;
      starve_d    = starve_q;
      if_rdata_d  = if_rdata_q;
      d_rdata_d   = d_rdata_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      if_gnt_d    = 1'b0;
      d_gnt_d     = 1'b0;
      if_rvalid_d = 1'b0;
      d_rvalid_d  = 1'b0;
      mem_en_d    = 1'b0;
      mem_we_d    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!if_req) starve_d = '0;
            if (if_req || d_req) begin
               state_d  = S_ISSUE;
               mem_en_d = 1'b1;
               if (d_wins) begin
                  owner_d     = 1'b1;
                  we_d        = d_we;
                  mem_we_d    = d_we;
                  mem_addr_d  = d_addr;
                  mem_wdata_d = d_wdata;
                  d_gnt_d     = 1'b1;
                  if (if_req && (starve_q != STARVE_CMP)) starve_d = starve_q + CW'(1);
               end else begin
                  owner_d     = 1'b0;
                  we_d        = 1'b0;
                  mem_addr_d  = if_addr;
                  mem_wdata_d = '0;
                  if_gnt_d    = 1'b1;
                  starve_d    = '0;
               end
            end
         end
         S_ISSUE: begin
            lat_d   = LW'(MEM_LAT - 1);
            state_d = we_q ? S_IDLE : S_WAIT;
         end
         S_WAIT: begin
            if (lat_q == '0) begin
               state_d = S_RESP;
               if (owner_q) begin
                  d_rdata_d  = mem_rdata;
                  d_rvalid_d = 1'b1;
               end else begin
                  if_rdata_d  = mem_rdata;
                  if_rvalid_d = 1'b1;
               end
            end else begin
               lat_d = lat_q - LW'(1);
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         owner_q     <= 1'b0;
         we_q        <= 1'b0;
         lat_q       <= '0;
         starve_q    <= '0;
         if_gnt_q    <= 1'b0;
         d_gnt_q     <= 1'b0;
         if_rvalid_q <= 1'b0;
         d_rvalid_q  <= 1'b0;
         if_rdata_q  <= '0;
         d_rdata_q   <= '0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         we_q        <= we_d;
         lat_q       <= lat_d;
         starve_q    <= starve_d;
         if_gnt_q    <= if_gnt_d;
         d_gnt_q     <= d_gnt_d;
         if_rvalid_q <= if_rvalid_d;
         d_rvalid_q  <= d_rvalid_d;
         if_rdata_q  <= if_rdata_d;
         d_rdata_q   <= d_rdata_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   assign if_gnt    = if_gnt_q;
   assign d_gnt     = d_gnt_q;
   assign if_rvalid = if_rvalid_q;
   assign d_rvalid  = d_rvalid_q;
   assign if_rdata  = if_rdata_q;
   assign d_rdata   = d_rdata_q;
   assign mem_en    = mem_en_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

`ifdef MEM_ARB_PERF_EN
   logic [31:0] perf_if_q, perf_if_d, perf_d_q, perf_d_d;

   // Wait cycles: request up while this port's grant pulse is low.
   always_comb begin
      perf_if_d = perf_if_q;
      perf_d_d  = perf_d_q;
      if (if_req && !if_gnt_q && (perf_if_q != 32'hFFFF_FFFF)) perf_if_d = perf_if_q + 32'd1;
      if (d_req && !d_gnt_q && (perf_d_q != 32'hFFFF_FFFF))    perf_d_d  = perf_d_q + 32'd1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         perf_if_q <= '0;
         perf_d_q  <= '0;
      end else begin
         perf_if_q <= perf_if_d;
         perf_d_q  <= perf_d_d;
      end
   end

   assign perf_if_wait = perf_if_q;
   assign perf_d_wait  = perf_d_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter with a RAM model and transaction-level reference
// Perf counters are checked when MEM_ARB_PERF_EN is defined.
module tb_mem_arbiter;

   localparam int AW  = 8;
   localparam int DW  = 32;
   localparam int LAT = 2;
   localparam int SM  = 4;

   logic          clk, reset;
   logic          if_req, if_gnt, if_rvalid;
   logic [AW-1:0] if_addr;
   logic [DW-1:0] if_rdata;
   logic          d_req, d_we, d_gnt, d_rvalid;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata, d_rdata;
   logic          mem_en, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;
`ifdef MEM_ARB_PERF_EN
   logic [31:0]   perf_if_wait, perf_d_wait;
`endif

   int checks   = 0;
   int failures = 0;

   logic          mem_init;
   logic [31:0]   ram     [256];
   logic [31:0]   ref_mem [256];
   logic [31:0]   pipe    [4];
   logic [3:0]    pvld;
   logic [15:0]   mcyc;

   mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT), .STARVE_MAX(SM)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
`ifdef MEM_ARB_PERF_EN
      , .perf_if_wait(perf_if_wait), .perf_d_wait(perf_d_wait)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] init_word(int a);
      if (a == 16) return 32'hDEAD_BEEF;
      return (32'(a) * 32'h9E37_79B9) ^ 32'h5A5A_5A5A;
   endfunction

   // RAM model: read data valid LAT cycles after the mem_en cycle, junk otherwise.
   always @(posedge clk) begin
      mcyc <= mem_init ? 16'd0 : mcyc + 16'd1;
      if (mem_init) begin
         for (int i = 0; i < 256; i++) ram[i] <= init_word(i);
         pvld <= '0;
      end else begin
         if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
         pipe[0] <= ram[mem_addr];
         pvld    <= {pvld[2:0], mem_en && !mem_we};
         for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
      end
   end

   always_comb mem_rdata = pvld[LAT-1] ? pipe[LAT-1] : {16'hBAD0, mcyc};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      checks++;
      if ({if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we} !== 6'b0 || mem_addr !== '0 ||
          mem_wdata !== '0 || if_rdata !== '0 || d_rdata !== '0) begin
         failures++;
         $display("FAIL reset_outputs: strobes=%b addr=%h wdata=%h if_rdata=%h d_rdata=%h, required all 0",
                  {if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we}, mem_addr, mem_wdata, if_rdata, d_rdata);
      end
   endtask

   task automatic test_single_fetch();
      if_addr = 8'h10;
      if_req  = 1'b1;
      tick();
      checks++;
      if ({if_gnt, d_gnt, mem_en, mem_we} !== 4'b1010 || mem_addr !== 8'h10) begin
         failures++;
         $display("FAIL fetch_issue: gnt/dgnt/en/we=%b addr=%h, required 1010 addr=10",
                  {if_gnt, d_gnt, mem_en, mem_we}, mem_addr);
      end
      if_req = 1'b0;
      for (int i = 1; i <= LAT + 1; i++) begin
         tick();
         if (i <= LAT) begin
            checks++;
            if ({if_gnt, mem_en, if_rvalid, d_rvalid} !== 4'b0) begin
               failures++;
               $display("FAIL fetch_gap: cycle %0d strobes=%b, required 0000", i, {if_gnt, mem_en, if_rvalid, d_rvalid});
            end
         end
      end
      checks++;
      if (if_rvalid !== 1'b1 || d_rvalid !== 1'b0 || if_rdata !== 32'hDEAD_BEEF) begin
         failures++;
         $display("FAIL fetch_resp: rvalid=%b d_rvalid=%b rdata=%h, required 1 0 deadbeef", if_rvalid, d_rvalid, if_rdata);
      end
      tick();
      checks++;
      if (if_rvalid !== 1'b0 || if_rdata !== 32'hDEAD_BEEF) begin
         failures++;
         $display("FAIL fetch_hold: rvalid=%b rdata=%h, required 0 deadbeef", if_rvalid, if_rdata);
      end
   endtask

   task automatic test_store_load();
      d_we = 1'b1; d_addr = 8'h05; d_wdata = 32'h1234_5678; d_req = 1'b1;
      ref_mem[5] = 32'h1234_5678;
      tick();
      checks++;
      if ({d_gnt, if_gnt, mem_en, mem_we} !== 4'b1011 || mem_addr !== 8'h05 || mem_wdata !== 32'h1234_5678) begin
         failures++;
         $display("FAIL store_issue: dgnt/gnt/en/we=%b addr=%h wdata=%h, required 1011 05 12345678",
                  {d_gnt, if_gnt, mem_en, mem_we}, mem_addr, mem_wdata);
      end
      d_req = 1'b0;
      tick();
      checks++;
      if ({d_gnt, mem_en, mem_we, d_rvalid} !== 4'b0 || mem_addr !== 8'h05 || mem_wdata !== 32'h1234_5678) begin
         failures++;
         $display("FAIL store_after: dgnt/en/we/rvalid=%b addr=%h wdata=%h, required 0000 05 12345678 held",
                  {d_gnt, mem_en, mem_we, d_rvalid}, mem_addr, mem_wdata);
      end
      d_we = 1'b0; d_wdata = 32'h0BAD_F00D; d_req = 1'b1;
      tick();
      checks++;
      if ({d_gnt, mem_en, mem_we} !== 3'b110 || mem_addr !== 8'h05) begin
         failures++;
         $display("FAIL load_issue: dgnt/en/we=%b addr=%h, required 110 05", {d_gnt, mem_en, mem_we}, mem_addr);
      end
      d_req = 1'b0;
      for (int i = 1; i <= LAT + 1; i++) begin
         tick();
         checks++;
         if (d_rvalid !== (i == LAT + 1) || if_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL load_rvalid: cycle %0d after gnt d_rvalid=%b if_rvalid=%b, required %0b 0",
                     i, d_rvalid, if_rvalid, (i == LAT + 1));
         end
      end
      checks++;
      if (d_rdata !== 32'h1234_5678) begin
         failures++;
         $display("FAIL load_data: got %h, required 12345678", d_rdata);
      end
      tick();
   endtask

   task automatic test_idle();
      for (int i = 0; i < 20; i++) begin
         tick();
         checks++;
         if ({mem_en, if_gnt, d_gnt, if_rvalid, d_rvalid} !== 5'b0) begin
            failures++;
            $display("FAIL idle_quiet: cycle %0d strobes=%b, required 00000", i, {mem_en, if_gnt, d_gnt, if_rvalid, d_rvalid});
         end
      end
   endtask

   task automatic test_contention();
      int ord [10];
      int ng = 0;
      d_we = 1'b1; d_addr = 8'hF0; d_wdata = 32'hC0FF_EE00; if_addr = 8'h20;
      ref_mem[8'hF0] = 32'hC0FF_EE00;
      d_req = 1'b1; if_req = 1'b1;
      for (int c = 0; c < 200 && ng < 10; c++) begin
         tick();
         if (if_gnt && d_gnt) begin
            checks++;
            failures++;
            $display("FAIL cont_dual_gnt: both gnt high at cycle %0d, required one-hot", c);
         end
         if (if_gnt) begin ord[ng] = 0; ng++; end
         else if (d_gnt) begin ord[ng] = 1; ng++; end
      end
      if_req = 1'b0; d_req = 1'b0;
      checks++;
      if (ng != 10) begin
         failures++;
         $display("FAIL cont_timeout: got %0d grants in 200 cycles, required 10", ng);
      end
      for (int k = 0; k < ng; k++) begin
         checks++;
         if (ord[k] != ((k % (SM + 1) == SM) ? 0 : 1)) begin
            failures++;
            $display("FAIL cont_order: grant %0d went to %s, required %s", k,
                     ord[k] == 1 ? "d" : "if", (k % (SM + 1) == SM) ? "if" : "d");
         end
      end
      for (int i = 0; i < LAT + 4; i++) tick();
   endtask

   task automatic test_reset_mid_read();
      if_addr = 8'h33; if_req = 1'b1;
      tick();
      if_req = 1'b0;
      checks++;
      if (if_gnt !== 1'b1) begin
         failures++;
         $display("FAIL rmr_gnt: got %b, required 1", if_gnt);
      end
      tick();
      #2 reset = 1'b0;
      #1;
      checks++;
      if ({if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we} !== 6'b0 || mem_addr !== '0 ||
          mem_wdata !== '0 || if_rdata !== '0 || d_rdata !== '0) begin
         failures++;
         $display("FAIL rmr_async: strobes=%b addr=%h if_rdata=%h, required all 0 without a clock edge",
                  {if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we}, mem_addr, if_rdata);
      end
      tick(); tick();
      reset = 1'b1;
      for (int i = 0; i < LAT + 4; i++) begin
         tick();
         checks++;
         if ({if_rvalid, d_rvalid, if_gnt, d_gnt, mem_en} !== 5'b0) begin
            failures++;
            $display("FAIL rmr_ghost: cycle %0d strobes=%b, required 00000", i, {if_rvalid, d_rvalid, if_gnt, d_gnt, mem_en});
         end
      end
      if_addr = 8'h44; if_req = 1'b1;
      tick();
      if_req = 1'b0;
      checks++;
      if ({if_gnt, mem_en} !== 2'b11 || mem_addr !== 8'h44) begin
         failures++;
         $display("FAIL rmr_refetch_gnt: gnt/en=%b addr=%h, required 11 44", {if_gnt, mem_en}, mem_addr);
      end
      for (int i = 0; i < LAT + 1; i++) tick();
      checks++;
      if (if_rvalid !== 1'b1 || if_rdata !== ref_mem[8'h44]) begin
         failures++;
         $display("FAIL rmr_refetch_data: rvalid=%b rdata=%h, required 1 %h", if_rvalid, if_rdata, ref_mem[8'h44]);
      end
      tick();
   endtask

`ifdef MEM_ARB_PERF_EN
   task automatic test_perf();
      int t = 0, n = 0, ig = 0, dg = 0;
      logic fetch;
      reset = 1'b0;
      tick(); tick();
      d_we = 1'b1; d_addr = 8'hF0; d_wdata = 32'hC0FF_EE00; if_addr = 8'h20;
      reset = 1'b1; d_req = 1'b1; if_req = 1'b1;
      for (int c = 0; c < 40; c++) tick();
      d_req = 1'b0; if_req = 1'b0;
      for (int i = 0; i < LAT + 4; i++) tick();
      while (t < 40) begin
         fetch = (n % (SM + 1) == SM);
         if (t + 1 < 40) begin
            if (fetch) ig++;
            else dg++;
         end
         t = t + (fetch ? LAT + 3 : 2);
         n++;
      end
      checks++;
      if (perf_if_wait !== 32'(40 - ig)) begin
         failures++;
         $display("FAIL perf_if_wait: got %0d, required %0d", perf_if_wait, 40 - ig);
      end
      checks++;
      if (perf_d_wait !== 32'(40 - dg)) begin
         failures++;
         $display("FAIL perf_d_wait: got %0d, required %0d", perf_d_wait, 40 - dg);
      end
   endtask
`endif

   task automatic test_random();
      int free_at = 0, starve = 0, eg_cyc = -1, er_cyc = -1;
      logic eg_d = 1'b0, eg_we = 1'b0, er_d = 1'b0, dwin;
      logic [7:0] eg_addr = '0;
      logic [31:0] eg_wdata = '0, er_data = '0;
      logic [1:0] exp_g, exp_r;
      if_req = 1'b0; d_req = 1'b0;
      tick();
      for (int c = 0; c < 440; c++) begin
         if (if_gnt) if_req = 1'b0;
         else if (!if_req && c < 400 && $urandom_range(0, 1) == 1) begin
            if_req = 1'b1; if_addr = 8'($urandom);
         end
         if (d_gnt) d_req = 1'b0;
         else if (!d_req && c < 400 && $urandom_range(0, 1) == 1) begin
            d_req = 1'b1; d_we = 1'($urandom_range(0, 1));
            d_addr = 8'($urandom_range(0, 15)); d_wdata = $urandom;
         end
         exp_g = (c == eg_cyc) ? (eg_d ? 2'b01 : 2'b10) : 2'b00;
         checks++;
         if ({if_gnt, d_gnt} !== exp_g || mem_en !== (c == eg_cyc)) begin
            failures++;
            $display("FAIL rnd_gnt: cycle %0d if/d gnt=%b en=%b, required %b %b", c, {if_gnt, d_gnt}, mem_en, exp_g, (c == eg_cyc));
         end
         if (c == eg_cyc) begin
            checks++;
            if (mem_we !== eg_we || mem_addr !== eg_addr || (eg_we && mem_wdata !== eg_wdata)) begin
               failures++;
               $display("FAIL rnd_fields: cycle %0d we=%b addr=%h wdata=%h, required %b %h %h",
                        c, mem_we, mem_addr, mem_wdata, eg_we, eg_addr, eg_wdata);
            end
         end
         exp_r = (c == er_cyc) ? (er_d ? 2'b01 : 2'b10) : 2'b00;
         checks++;
         if ({if_rvalid, d_rvalid} !== exp_r) begin
            failures++;
            $display("FAIL rnd_rvalid: cycle %0d if/d rvalid=%b, required %b", c, {if_rvalid, d_rvalid}, exp_r);
         end
         if (c == er_cyc) begin
            checks++;
            if ((er_d ? d_rdata : if_rdata) !== er_data) begin
               failures++;
               $display("FAIL rnd_rdata: cycle %0d got %h, required %h", c, er_d ? d_rdata : if_rdata, er_data);
            end
         end
         // Reference: one transaction at a time, arbitration only when the block is free.
         if (c >= free_at) begin
            if (!if_req) starve = 0;
            if (if_req || d_req) begin
               dwin     = d_req && !(if_req && starve == SM);
               eg_cyc   = c + 1;
               eg_d     = dwin;
               eg_we    = dwin && d_we;
               eg_addr  = dwin ? d_addr : if_addr;
               eg_wdata = d_wdata;
               if (eg_we) begin
                  ref_mem[d_addr] = d_wdata;
                  free_at = c + 2;
               end else begin
                  er_cyc  = c + 2 + LAT;
                  er_d    = dwin;
                  er_data = ref_mem[eg_addr];
                  free_at = c + 3 + LAT;
               end
               if (!dwin) starve = 0;
               else if (if_req && starve < SM) starve++;
            end
         end
         tick();
      end
   endtask

   initial begin
      reset = 1'b0; mem_init = 1'b1;
      if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
      for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
      tick(); tick();
      mem_init = 1'b0;
      test_reset();
      reset = 1'b1;
      tick();
      test_single_fetch();
      test_store_load();
      test_idle();
      test_contention();
      test_reset_mid_read();
`ifdef MEM_ARB_PERF_EN
      test_perf();
`endif
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
